// File: rtl/wblock_sched.sv
// Frame-level block scheduler: tiles each frame into ROW_BLOCKS x COL_BLOCKS regions,
// sums the pixels of each region and hands finished sums to the serializer over valid/ready.
module wblock_sched #(
    parameter int          COL_BLOCK_WIDE   = 200,
    parameter int          COL_BLOCKS       = 4,
    parameter int          ROW_BLOCK_HEIGHT = 3,
    parameter int          ROW_BLOCKS       = 4,
    parameter int          SUM_SIZE         = 16,
    parameter logic [7:0]  HEADER           = 8'h55
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  din,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic        overrun,
    output logic [1:0]  o_dbg_state
);

    // Output handshake: a word transfers on any rising edge where out_valid and out_ready
    // are both 1; out_data holds still while out_valid=1 until that edge.

    localparam int PW = (COL_BLOCK_WIDE   > 1) ? $clog2(COL_BLOCK_WIDE)   : 1;
    localparam int CW = (COL_BLOCKS       > 1) ? $clog2(COL_BLOCKS)       : 1;
    localparam int LW = (ROW_BLOCK_HEIGHT > 1) ? $clog2(ROW_BLOCK_HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_FRAME = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_vsync_d;
    logic                  r_href_d;
    logic [PW-1:0]         r_pix_cnt;
    logic [CW-1:0]         r_col_blk;
    logic                  r_past;
    logic [LW-1:0]         r_line_in_blk;
    logic [3:0]            r_row_blk;
    logic [SUM_SIZE-1:0]   r_acc [COL_BLOCKS];
    logic                  r_out_valid;
    logic [31:0]           r_out_data;
    logic                  r_overrun;
    logic                  r_frame_err;

    logic                  w_vs_rise;
    logic                  w_vs_fall;
    logic                  w_line_end;
    logic                  w_last_line;
    logic                  w_last_pix;
    logic                  w_frame_end;
    logic                  w_pix;
    logic                  w_load;
    logic                  w_frame_err;
    logic                  w_frame_done;
    logic [SUM_SIZE-1:0]   w_sum;

    assign w_vs_rise   = vsync & ~r_vsync_d;
    assign w_vs_fall   = ~vsync & r_vsync_d;
    assign w_line_end  = (r_state == S_FRAME) && r_href_d && !href;
    assign w_last_line = (r_line_in_blk == LW'(ROW_BLOCK_HEIGHT - 1));
    assign w_last_pix  = (r_pix_cnt == PW'(COL_BLOCK_WIDE - 1));
    assign w_frame_end = w_line_end && w_last_line && (r_row_blk == 4'(ROW_BLOCKS - 1));
    assign w_pix       = (r_state == S_FRAME) && href && !r_past;
    assign w_load      = w_pix && w_last_line && w_last_pix;
    assign w_sum       = r_acc[r_col_blk] + {{(SUM_SIZE-8){1'b0}}, din};

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_vsync_d <= vsync;
            r_href_d  <= href;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_frame_err  = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_vs_rise) w_next = S_SYNC;
            end
            S_SYNC: begin
                if (w_vs_fall) w_next = S_FRAME;
            end
            S_FRAME: begin
                // A new vsync mid-frame wins over a coincident last-line end.
                if (w_vs_rise) begin
                    w_next      = S_SYNC;
                    w_frame_err = 1'b1;
                end else if (w_frame_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_pix_cnt     <= '0;
            r_col_blk     <= '0;
            r_past        <= 1'b0;
            r_line_in_blk <= '0;
            r_row_blk     <= '0;
            for (int i = 0; i < COL_BLOCKS; i++) r_acc[i] <= '0;
        end else if (r_state == S_SYNC) begin
            r_pix_cnt     <= '0;
            r_col_blk     <= '0;
            r_past        <= 1'b0;
            r_line_in_blk <= '0;
            r_row_blk     <= '0;
            for (int i = 0; i < COL_BLOCKS; i++) r_acc[i] <= '0;
        end else if (w_line_end) begin
            r_pix_cnt <= '0;
            r_col_blk <= '0;
            r_past    <= 1'b0;
            if (w_last_line) begin
                // Blocks left incomplete by a short last line are dropped here.
                r_line_in_blk <= '0;
                r_row_blk     <= r_row_blk + 4'd1;
                for (int i = 0; i < COL_BLOCKS; i++) r_acc[i] <= '0;
            end else begin
                r_line_in_blk <= r_line_in_blk + LW'(1);
            end
        end else if (w_pix) begin
            r_acc[r_col_blk] <= w_load ? '0 : w_sum;
            if (w_last_pix) begin
                r_pix_cnt <= '0;
                if (r_col_blk == CW'(COL_BLOCKS - 1)) r_past <= 1'b1;
                else                                  r_col_blk <= r_col_blk + CW'(1);
            end else begin
                r_pix_cnt <= r_pix_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (r_state == S_SYNC) r_overrun <= 1'b0;
            if (w_load) begin
                // Single holding slot: a result arriving while it is blocked is lost.
                if (r_out_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= {HEADER, r_row_blk, 4'(r_col_blk), w_sum[15:0]};
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign frame_done  = w_frame_done;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: doc/wblock_sched.md
# wblock_sched

Frame-level scheduler for the weight-coding datapath. Tracks `vsync`/`href` to tile each frame into a grid of `ROW_BLOCKS` x `COL_BLOCKS` regions. Accumulates pixel sums per region across all lines of a row block. Hands each finished region sum, tagged with header and grid coordinates, to the byte serializer over a valid/ready handshake. Sits between the camera pixel bus and the serializer, replacing the single-line column summer.

## Interface
- `COL_BLOCK_WIDE`, 200, pixels per column block
- `COL_BLOCKS`, 4, column blocks per line (max 16)
- `ROW_BLOCK_HEIGHT`, 3, lines per row block
- `ROW_BLOCKS`, 4, row blocks per frame (max 16)
- `SUM_SIZE`, 16, accumulator width (fixed at 16 for the output word)
- `HEADER`, 8'h55, tag byte placed in each output word
- `pclk` in 1: pixel clock; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `vsync` in 1: frame sync, high between frames
- `href` in 1: line valid, high while `din` carries pixels
- `din` in 8: pixel value
- `out_ready` in 1: serializer can accept a word
- `out_valid` out 1: `out_data` holds an unsent result
- `out_data` out 32: `{HEADER, row_blk[3:0], col_blk[3:0], sum[15:0]}`
- `frame_done` out 1: one-cycle pulse when the last region of a frame is complete
- `frame_err` out 1: one-cycle pulse when a frame is aborted by `vsync`
- `overrun` out 1: sticky; a result was dropped because the holding register was full

## Operation
- Registered copies `vsync_d` and `href_d` provide edge detection. All inputs are sampled on the `pclk` rising edge.
- The FSM has four states: IDLE, SYNC, FRAME, DONE.
  - IDLE: the state after reset. `vsync` rising -> SYNC.
  - SYNC: clears line, row-block and pixel counters, all accumulators, and `overrun`. `vsync` falling -> FRAME.
  - FRAME: accumulates pixels.
    - After `ROW_BLOCKS*ROW_BLOCK_HEIGHT` counted lines -> DONE.
    - `vsync` rising -> SYNC with a `frame_err` pulse.
  - DONE: pulses `frame_done` for one cycle -> IDLE.
  - `href` is ignored outside FRAME.
- Pixel path (FRAME, `href`=1):
  - `pix_cnt` counts 0..`COL_BLOCK_WIDE`-1 and `col_blk` counts 0..`COL_BLOCKS`-1.
  - `acc[col_blk]` accumulates `din` (zero-extended), wrapping modulo 2^`SUM_SIZE`.
  - Pixels past `COL_BLOCKS*COL_BLOCK_WIDE` in a line are ignored.
- A line is counted on the `href` falling edge. `pix_cnt` and `col_blk` reset to 0 at that edge. `line_in_blk` counts 0..`ROW_BLOCK_HEIGHT`-1, then `row_blk` increments.
- Emission: on the last pixel of a column block on the last line of a row block (`line_in_blk`=`ROW_BLOCK_HEIGHT`-1):
  - the result `acc+din` loads the holding register with the current `row_blk`/`col_blk`;
  - `acc[col_blk]` clears to 0.
- Short last line: any block not completed is not emitted. All accumulators clear on that line's `href` falling edge.
- Holding register: one entry.
  - A load while `out_valid`=1 and `out_ready`=0 drops the new result and sets `overrun`.
  - A load in the same cycle as a transfer is accepted.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `frame_done`=0, `frame_err`=0, `overrun`=0, state IDLE, all counters and accumulators 0.
- Latency: the edge that samples the final pixel of a region loads `out_data` and sets `out_valid`. The result is visible in the following cycle.
- Transfer: occurs on the edge where `out_valid`=1 and `out_ready`=1. `out_valid` clears after that edge unless a load occurs on the same edge, in which case it stays 1 with the new data.
- `out_data` is stable while `out_valid`=1 and no transfer has occurred.
- `frame_done` is asserted the cycle after the last line's `href` falling edge is sampled.
- Reset mid-frame returns to IDLE immediately. A pending result is discarded.
- A `vsync` rise in FRAME discards partial accumulators. `overrun` stays set until the next SYNC entry.

## Test plan
- Small grid (`COL_BLOCK_WIDE`=4, `COL_BLOCKS`=2, `ROW_BLOCK_HEIGHT`=2, `ROW_BLOCKS`=2), `din`=1, `out_ready`=1, 4 lines of 8 pixels -> 4 words with sum 8:
  - `0x5500_0008`, `0x5501_0008`, `0x5510_0008`, `0x5511_0008`;
  - then `frame_done` pulses once.
- Default parameters, `din`=255 for a full row block of 3x200 pixels -> col block 0 sum = 153000 mod 65536 = `0x55A8`; `out_data`=`0x5500_55A8`.
- Small grid with `out_ready`=0 held -> the first word is held stable, the second is dropped, and `overrun`=1. Raising `out_ready` transfers the first word only. `overrun` clears at the next `vsync`.
- Small grid, last line of a row block with `href` low after 6 pixels -> col 0 is emitted and col 1 is not. The next row block's col 1 sum counts only its own pixels.
- `vsync` rises after 2 lines -> `frame_err` pulses, no `frame_done`. The next frame's first word reflects only new pixels.
- `rst` asserted while `out_valid`=1 -> `out_valid`=0 and `out_data`=0 immediately, state IDLE, and `href` pulses are ignored until `vsync` rises then falls.
